// File: rtl/fifo_stream_arbiter_pkg.sv
// Shared definitions for the FE/TLU stream arbiter: grant states and data-word width.
package fifo_stream_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FE,
    ST_TLU
  } state_t;

endpackage

// File: rtl/fifo_stream_arbiter.sv
// Merges the FE-I4 receiver stream and the TLU trigger stream into one registered FWFT stream
// with bounded FE bursts, per-source word counters and a sticky read-while-empty flag.
module fifo_stream_arbiter
  import fifo_stream_arbiter_pkg::*;
#(
  parameter int unsigned MAX_FE_BURST = 16,
  parameter bit          TLU_PRIORITY = 1'b1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_B,
  input  logic                 FE_ENABLE,
  input  logic                 TLU_ENABLE,
  output logic                 FE_FIFO_READ,
  input  logic                 FE_FIFO_EMPTY,
  input  logic [DATA_W-1:0]    FE_FIFO_DATA,
  output logic                 TLU_FIFO_READ,
  input  logic                 TLU_FIFO_EMPTY,
  input  logic [DATA_W-1:0]    TLU_FIFO_DATA,
  input  logic                 FIFO_READ,
  output logic                 FIFO_EMPTY,
  output logic [DATA_W-1:0]    FIFO_DATA,
  output logic [CNT_WIDTH-1:0] FE_WORD_CNT,
  output logic [CNT_WIDTH-1:0] TLU_WORD_CNT,
  output logic                 READ_ERROR
);

  localparam int unsigned BURST_W = $clog2(MAX_FE_BURST + 1);

  state_t              state, state_nxt;
  logic [BURST_W-1:0]  burst_cnt, burst_nxt;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                fe_req, tlu_req, can_load, burst_full;
  logic                fe_pop, tlu_pop, load;
  logic [DATA_W-1:0]   load_data;

  always_comb begin
    fe_req     = FE_ENABLE & ~FE_FIFO_EMPTY;
    tlu_req    = TLU_ENABLE & ~TLU_FIFO_EMPTY;
    can_load   = ~out_valid | FIFO_READ;
    burst_full = (burst_cnt == BURST_W'(MAX_FE_BURST));
    state_nxt  = state;
    burst_nxt  = burst_cnt;
    fe_pop     = 1'b0;
    tlu_pop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tlu_req && (TLU_PRIORITY || !fe_req)) state_nxt = ST_TLU;
        else if (fe_req)                          state_nxt = ST_FE;
      end
      ST_FE: begin
        // Burst-limit handover waits out a stall; disable/empty exits do not.
        if (!fe_req || (burst_full && tlu_req && can_load)) begin
          state_nxt = tlu_req ? ST_TLU : ST_IDLE;
          burst_nxt = '0;
        end else if (can_load) begin
          fe_pop = 1'b1;
          if (!burst_full) burst_nxt = burst_cnt + BURST_W'(1);
        end
      end
      ST_TLU: begin
        if (!tlu_req) begin
          state_nxt = ST_IDLE;
        end else if (can_load) begin
          tlu_pop   = 1'b1;
          state_nxt = fe_req ? ST_FE : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    load      = fe_pop | tlu_pop;
    load_data = fe_pop ? FE_FIFO_DATA : TLU_FIFO_DATA;
  end

  assign FE_FIFO_READ  = fe_pop;
  assign TLU_FIFO_READ = tlu_pop;
  assign FIFO_EMPTY    = ~out_valid;
  assign FIFO_DATA     = out_data;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (FIFO_READ) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      FE_WORD_CNT  <= '0;
      TLU_WORD_CNT <= '0;
      READ_ERROR   <= 1'b0;
    end else begin
      if (fe_pop)                 FE_WORD_CNT  <= FE_WORD_CNT + CNT_WIDTH'(1);
      if (tlu_pop)                TLU_WORD_CNT <= TLU_WORD_CNT + CNT_WIDTH'(1);
      if (FIFO_READ && !out_valid) READ_ERROR  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Scoreboard bench for fifo_stream_arbiter: queue-modelled source FIFOs, per-source expected
// streams, and directed ordering checks for burst limit, priority, reset and disable.
module tb_fifo_stream_arbiter;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_B, FE_ENABLE, TLU_ENABLE, FE_FIFO_EMPTY, TLU_FIFO_EMPTY, FIFO_READ;
  logic [31:0] FE_FIFO_DATA, TLU_FIFO_DATA, FIFO_DATA;
  logic        FE_FIFO_READ, TLU_FIFO_READ, FIFO_EMPTY, READ_ERROR;
  logic [15:0] FE_WORD_CNT, TLU_WORD_CNT;

  logic        p0_fe_read, p0_tlu_read, p0_empty, p0_err;
  logic [31:0] p0_data;
  logic [15:0] p0_fe_cnt, p0_tlu_cnt;

  localparam logic [31:0] P0_FE_WORD  = 32'h0000_0F0F;
  localparam logic [31:0] P0_TLU_WORD = 32'h8000_0F0F;

  always #5 BUS_CLK = ~BUS_CLK;

  fifo_stream_arbiter #(.MAX_FE_BURST(16), .TLU_PRIORITY(1'b1), .CNT_WIDTH(16)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_B(BUS_RST_B),
    .FE_ENABLE(FE_ENABLE), .TLU_ENABLE(TLU_ENABLE),
    .FE_FIFO_READ(FE_FIFO_READ), .FE_FIFO_EMPTY(FE_FIFO_EMPTY), .FE_FIFO_DATA(FE_FIFO_DATA),
    .TLU_FIFO_READ(TLU_FIFO_READ), .TLU_FIFO_EMPTY(TLU_FIFO_EMPTY), .TLU_FIFO_DATA(TLU_FIFO_DATA),
    .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .FE_WORD_CNT(FE_WORD_CNT), .TLU_WORD_CNT(TLU_WORD_CNT), .READ_ERROR(READ_ERROR)
  );

  // FE-priority instance with permanently full sources and no reader.
  fifo_stream_arbiter #(.MAX_FE_BURST(16), .TLU_PRIORITY(1'b0), .CNT_WIDTH(16)) dut_p0 (
    .BUS_CLK(BUS_CLK), .BUS_RST_B(BUS_RST_B),
    .FE_ENABLE(1'b1), .TLU_ENABLE(1'b1),
    .FE_FIFO_READ(p0_fe_read), .FE_FIFO_EMPTY(1'b0), .FE_FIFO_DATA(P0_FE_WORD),
    .TLU_FIFO_READ(p0_tlu_read), .TLU_FIFO_EMPTY(1'b0), .TLU_FIFO_DATA(P0_TLU_WORD),
    .FIFO_READ(1'b0), .FIFO_EMPTY(p0_empty), .FIFO_DATA(p0_data),
    .FE_WORD_CNT(p0_fe_cnt), .TLU_WORD_CNT(p0_tlu_cnt), .READ_ERROR(p0_err)
  );

  logic [31:0] fe_q[$], tlu_q[$], exp_fe[$], exp_tlu[$], out_log[$];
  int          n_chk = 0, n_fail = 0;
  int unsigned n_fe = 0, n_tlu = 0;
  logic        rd_full = 1'b1, err_pulse = 1'b0;
  logic        fe_rd_s = 1'b0, tlu_rd_s = 1'b0;
  logic [31:0] mon_w, exp_w;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function void refresh();
    FE_FIFO_EMPTY  = (fe_q.size() == 0);
    FE_FIFO_DATA   = FE_FIFO_EMPTY ? 32'h0 : fe_q[0];
    TLU_FIFO_EMPTY = (tlu_q.size() == 0);
    TLU_FIFO_DATA  = TLU_FIFO_EMPTY ? 32'h0 : tlu_q[0];
  endfunction

  task automatic push_fe(input logic [31:0] w);
    fe_q.push_back(w); exp_fe.push_back(w); n_fe++; refresh();
  endtask

  task automatic push_tlu(input logic [31:0] w);
    tlu_q.push_back(w); exp_tlu.push_back(w); n_tlu++; refresh();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge BUS_CLK);
    #1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (!(fe_q.size() == 0 && tlu_q.size() == 0 && FIFO_EMPTY) && k < 3000) begin
      cyc(1); k++;
    end
    cyc(3);
    chk({name, "_drain_timeout"}, 32'(k >= 3000), 32'd0);
    chk({name, "_fe_left"}, 32'(exp_fe.size()), 32'd0);
    chk({name, "_tlu_left"}, 32'(exp_tlu.size()), 32'd0);
    chk({name, "_fe_cnt"}, 32'(FE_WORD_CNT), 32'(16'(n_fe)));
    chk({name, "_tlu_cnt"}, 32'(TLU_WORD_CNT), 32'(16'(n_tlu)));
  endtask

  // Source FIFO models: strobes sampled mid-cycle, popped on the edge.
  always @(negedge BUS_CLK) begin
    fe_rd_s  = FE_FIFO_READ;
    tlu_rd_s = TLU_FIFO_READ;
    if (FE_FIFO_READ || TLU_FIFO_READ) begin
      n_chk++;
      if ((FE_FIFO_READ && fe_q.size() == 0) || (TLU_FIFO_READ && tlu_q.size() == 0) ||
          (FE_FIFO_READ && TLU_FIFO_READ)) begin
        n_fail++;
        $display("FAIL src_read: fe_read=%b fe_level=%0d tlu_read=%b tlu_level=%0d required single pop from non-empty source",
                 FE_FIFO_READ, fe_q.size(), TLU_FIFO_READ, tlu_q.size());
      end
    end
  end

  always @(posedge BUS_CLK) begin
    if (fe_rd_s && fe_q.size() > 0)   void'(fe_q.pop_front());
    if (tlu_rd_s && tlu_q.size() > 0) void'(tlu_q.pop_front());
    fe_rd_s  = 1'b0;
    tlu_rd_s = 1'b0;
    refresh();
  end

  initial begin
    FIFO_READ = 1'b0;
    forever begin
      @(posedge BUS_CLK);
      #2;
      FIFO_READ = err_pulse | ((rd_full || ($urandom_range(99) < 30)) & ~FIFO_EMPTY);
    end
  end

  // Monitor: every consumed output word is matched against its source's expected stream.
  always @(negedge BUS_CLK) begin
    if (BUS_RST_B && !FIFO_EMPTY && FIFO_READ) begin
      mon_w = FIFO_DATA;
      out_log.push_back(mon_w);
      if (mon_w[31]) begin
        if (exp_tlu.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tlu_stream: got %h expected no TLU word", mon_w);
        end else begin
          exp_w = exp_tlu.pop_front();
          chk("tlu_stream", mon_w, exp_w);
        end
      end else begin
        if (exp_fe.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL fe_stream: got %h expected no FE word", mon_w);
        end else begin
          exp_w = exp_fe.pop_front();
          chk("fe_stream", mon_w, exp_w);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    int base;
    int found;
    logic [31:0] seq[$];
    BUS_RST_B = 1'b0;
    FE_ENABLE = 1'b1;
    TLU_ENABLE = 1'b1;
    refresh();
    #12;
    chk("rst_empty", 32'(FIFO_EMPTY), 32'd1);
    chk("rst_data", FIFO_DATA, 32'h0);
    chk("rst_reads", 32'({FE_FIFO_READ, TLU_FIFO_READ}), 32'd0);
    chk("rst_cnts", {FE_WORD_CNT, TLU_WORD_CNT}, 32'h0);
    chk("rst_err", 32'(READ_ERROR), 32'd0);
    @(negedge BUS_CLK);
    BUS_RST_B = 1'b1;
    cyc(5);

    chk("p0_first_valid", 32'(p0_empty), 32'd0);
    chk("p0_first_is_fe", p0_data, P0_FE_WORD);
    chk("p0_cnts", {p0_fe_cnt, p0_tlu_cnt}, {16'd1, 16'd0});
    chk("p0_stall_reads", 32'({p0_fe_read, p0_tlu_read, p0_err}), 32'd0);

    // 1: FE only, five words
    base = out_log.size();
    for (int i = 0; i < 5; i++) push_fe(32'h0000_00A0 + 32'(i));
    drain("t1");
    chk("t1_len", 32'(out_log.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) chk("t1_word", out_log[base + i], 32'h0000_00A0 + 32'(i));
    chk("t1_err", 32'(READ_ERROR), 32'd0);

    // 2: burst limit hands over to a pending TLU word
    base = out_log.size();
    seq.delete();
    for (int i = 0; i < 40; i++) push_fe(32'h0002_0000 + 32'(i));
    cyc(3);
    push_tlu(32'h8000_0001);
    for (int i = 0; i < 16; i++) seq.push_back(32'h0002_0000 + 32'(i));
    seq.push_back(32'h8000_0001);
    for (int i = 16; i < 40; i++) seq.push_back(32'h0002_0000 + 32'(i));
    drain("t2");
    chk("t2_len", 32'(out_log.size() - base), 32'd41);
    for (int i = 0; i < 41; i++)
      if (base + i < out_log.size()) chk("t2_order", out_log[base + i], seq[i]);

    // 3: tie from IDLE with TLU priority
    base = out_log.size();
    push_tlu(32'h8000_0003);
    push_fe(32'h0000_0003);
    drain("t3");
    chk("t3_len", 32'(out_log.size() - base), 32'd2);
    if (out_log.size() >= base + 2) begin
      chk("t3_first_tlu", out_log[base], 32'h8000_0003);
      chk("t3_second_fe", out_log[base + 1], 32'h0000_0003);
    end

    // 4: random traffic under random backpressure
    rd_full = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 40) push_fe({1'b0, 31'($urandom)});
      if ($urandom_range(99) < 6)  push_tlu({1'b1, 31'(i)});
      cyc(1);
    end
    drain("t4");
    rd_full = 1'b1;

    // 5: read while empty sets the sticky error
    chk("t5_err_before", 32'(READ_ERROR), 32'd0);
    err_pulse = 1'b1;
    cyc(1);
    err_pulse = 1'b0;
    cyc(3);
    chk("t5_err_set", 32'(READ_ERROR), 32'd1);
    chk("t5_still_empty", 32'(FIFO_EMPTY), 32'd1);
    chk("t5_cnt_same", 32'(FE_WORD_CNT), 32'(16'(n_fe)));
    cyc(5);
    chk("t5_err_sticky", 32'(READ_ERROR), 32'd1);

    // 6a: asynchronous reset in the middle of an FE burst
    for (int i = 0; i < 20; i++) push_fe(32'h0006_0000 + 32'(i));
    cyc(6);
    #2;
    BUS_RST_B = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(FIFO_EMPTY), 32'd1);
    chk("t6_rst_cnts", {FE_WORD_CNT, TLU_WORD_CNT}, 32'h0);
    chk("t6_rst_err", 32'(READ_ERROR), 32'd0);
    chk("t6_rst_reads", 32'({FE_FIFO_READ, TLU_FIFO_READ}), 32'd0);
    fe_q.delete(); tlu_q.delete(); exp_fe.delete(); exp_tlu.delete();
    n_fe = 0; n_tlu = 0;
    refresh();
    @(negedge BUS_CLK);
    BUS_RST_B = 1'b1;
    cyc(1);
    base = out_log.size();
    for (int i = 0; i < 3; i++) push_fe(32'h0006_1000 + 32'(i));
    drain("t6a");
    chk("t6a_len", 32'(out_log.size() - base), 32'd3);

    // 6b: FE disabled mid-burst, pending TLU word goes through
    base = out_log.size();
    for (int i = 0; i < 30; i++) push_fe(32'h0007_0000 + 32'(i));
    cyc(5);
    push_tlu(32'h8000_0006);
    FE_ENABLE = 1'b0;
    cyc(12);
    found = 0;
    for (int i = base; i < out_log.size(); i++) if (out_log[i] == 32'h8000_0006) found = 1;
    chk("t6b_tlu_forwarded", 32'(found), 32'd1);
    chk("t6b_fe_held", 32'(exp_fe.size() > 0), 32'd1);
    FE_ENABLE = 1'b1;
    drain("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
